// File: rtl/mdr_mem_interface.sv
// mdr_mem_interface: MAR/MDR pair with a timed memory read/write handshake.
// A sticky mem_err flags transfers aborted after TIMEOUT cycles without mem_ack.
module mdr_mem_interface #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic              mem_ack,
  input  logic [31:0]       Mdatain,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       busMDRin,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, FIN} state_t;
  state_t            state;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] mar;
  logic [31:0]       mdr;
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      state   <= IDLE;
      count   <= '0;
      mar     <= '0;
      mdr     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
          // a read start takes priority and drops a simultaneous write
          if (MDRin && Read) begin
            state   <= RD_WAIT;
            count   <= '0;
            mem_err <= 1'b0;
          end else begin
            if (MDRin) mdr <= BusMuxOut;
            if (Write) begin
              state   <= WR_WAIT;
              count   <= '0;
              mem_err <= 1'b0;
            end
          end
        end
        RD_WAIT, WR_WAIT:
          if (mem_ack) begin
            if (state == RD_WAIT) mdr <= Mdatain;
            state <= FIN;
          end else if (count == CW'(TIMEOUT - 1)) begin
            mem_err <= 1'b1;
            state   <= FIN;
          end else count <= count + 1'b1;
        default: state <= IDLE;
      endcase
    end
  assign mem_addr   = mar;
  assign mem_wdata  = mdr;
  assign busMDRin   = mdr;
  assign mem_rd_req = state == RD_WAIT;
  assign mem_wr_req = state == WR_WAIT;
  assign busy       = mem_rd_req || mem_wr_req;
  assign done       = state == FIN;
endmodule

// File: doc/mdr_mem_interface.md
MDR_MEM_INTERFACE -- requirements
Module: mdr_mem_interface

Interface
REQ-001 Parameter ADDR_W, default 9: memory address width; MAR holds the low ADDR_W bits of the bus.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ack before the transfer aborts.
REQ-003 clock  input  1  Single system clock; all state SHALL update on its rising edge.
REQ-004 clear  input  1  Asynchronous active-high reset.
REQ-005 BusMuxOut  input  32  Bus value from the bus multiplexer.
REQ-006 MARin  input  1  Load strobe for MAR.
REQ-007 MDRin  input  1  Load strobe for MDR.
REQ-008 Read  input  1  With MDRin, selects a memory read instead of a bus load.
REQ-009 Write  input  1  Starts a memory write of MDR to address MAR.
REQ-010 mem_ack  input  1  Memory completion acknowledge.
REQ-011 Mdatain  input  32  Memory read data, valid when mem_ack=1.
REQ-012 mem_addr  output  ADDR_W  Current MAR value.
REQ-013 mem_rd_req  output  1  Read request to memory.
REQ-014 mem_wr_req  output  1  Write request to memory.
REQ-015 mem_wdata  output  32  Current MDR value.
REQ-016 busMDRin  output  32  MDR contents driven to the bus multiplexer's MDR input.
REQ-017 busy  output  1  High while a memory transfer is outstanding.
REQ-018 done  output  1  One-cycle pulse when a transfer completes or aborts.
REQ-019 mem_err  output  1  Sticky timeout flag.

Function
REQ-020 The FSM SHALL have four states: IDLE, RD_WAIT, WR_WAIT, FIN.
REQ-021 IDLE, MARin=1: MAR <= BusMuxOut[ADDR_W-1:0] at the next edge.
REQ-022 IDLE, MDRin=1, Read=0: MDR <= BusMuxOut at the next edge; state stays IDLE.
REQ-023 IDLE, MDRin=1, Read=1: next state RD_WAIT, count <= 0, mem_err <= 0.
REQ-024 IDLE, Write=1, and no read started: next state WR_WAIT, count <= 0, mem_err <= 0.
REQ-025 If a read and a write start in the same cycle, the read SHALL win and the write SHALL be dropped.
REQ-026 mem_rd_req SHALL equal 1 exactly in RD_WAIT; mem_wr_req SHALL equal 1 exactly in WR_WAIT; busy = RD_WAIT or WR_WAIT.
REQ-027 RD_WAIT, mem_ack=1: MDR <= Mdatain; next state FIN.
REQ-028 WR_WAIT, mem_ack=1: MDR unchanged; next state FIN.
REQ-029 WAIT states, mem_ack=0, count < TIMEOUT-1: count <= count+1; state holds.
REQ-030 WAIT states, mem_ack=0, count = TIMEOUT-1: mem_err <= 1, MDR unchanged, next state FIN; first-cycle latency to abort = TIMEOUT cycles.
REQ-031 FIN: done=1 for exactly that cycle; next state IDLE unconditionally.
REQ-032 MARin, MDRin, Read and Write SHALL be ignored in RD_WAIT, WR_WAIT and FIN; MAR and MDR stay stable.
REQ-033 mem_ack in IDLE or FIN SHALL be ignored.
REQ-034 Minimum transfer latency: request asserted in the cycle after the start; ack in that cycle -> FIN the following cycle -> IDLE again.
REQ-035 count SHALL be wide enough for TIMEOUT and SHALL NOT wrap while in a WAIT state.

Reset
REQ-036 clear=1 SHALL immediately force: state IDLE, MAR=0, MDR=0, count=0, mem_err=0, all request outputs, busy and done = 0, busMDRin = 0.
REQ-037 clear asserted mid-transfer SHALL abort the transfer with no done pulse.

Verification
REQ-038 Bus load: BusMuxOut=0xDEADBEEF, MDRin=1, Read=0 for 1 cycle -> busMDRin=0xDEADBEEF next cycle, busy=0, done=0.
REQ-039 Read: MARin with 0x1F5 -> mem_addr=0x1F5; MDRin=Read=1 -> mem_rd_req=1; ack after 3 cycles with Mdatain=0x12345678 -> busMDRin=0x12345678, done pulse, 1 cycle, then IDLE.
REQ-040 Write: MDR=0xA5A5A5A5, Write=1 -> mem_wr_req=1, mem_wdata=0xA5A5A5A5; on ack -> done=1, MDR unchanged.
REQ-041 Timeout: read with no ack -> mem_rd_req held 15 cycles, then mem_err=1 and done=1, MDR unchanged; the next read start clears mem_err.
REQ-042 Conflicts: MDRin=Read=1 and Write=1 together -> only mem_rd_req asserts; MARin=1 with 0x0AA during RD_WAIT -> mem_addr unchanged.
REQ-043 Reset mid-read: clear during RD_WAIT -> mem_rd_req=0, busy=0, MDR=0 immediately; no done pulse.
